// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches the PS/2 pins,
// deframes 11-bit device frames, checks parity/stop and folds E0/F0
// prefixes into flags, emitting one strobe per complete scancode.
//
// Ports:
//   i_clk        system clock (10 MHz)
//   i_rst        synchronous active-high reset
//   i_ps2_clk    raw PS/2 clock pin (asynchronous)
//   i_ps2_data   raw PS/2 data pin (asynchronous)
//   o_valid      one-cycle strobe, o_code/o_break/o_ext updated
//   o_code       scancode byte with prefixes stripped
//   o_break      code was preceded by F0
//   o_ext        code was preceded by E0
//   o_err        one-cycle strobe: parity, stop or timeout error
//   o_busy       frame in progress
//
// Optional feature: define PS2_RX_TIMEOUT_EN to abandon partial frames
// after TIMEOUT_CYCLES cycles without a filtered clock edge.
module ps2_kbd_rx #(
    parameter int FILTER_LEN = 4
`ifdef PS2_RX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 20000
`endif
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_valid,
    output logic [7:0] o_code,
    output logic       o_break,
    output logic       o_ext,
    output logic       o_err,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state;
    logic                    clk_s1, clk_s2;
    logic                    dat_s1, dat_s2;
    logic [FILTER_LEN-1:0]   filt_sr;
    logic                    filt_clk;
    logic                    filt_lo, filt_hi;
    logic                    fall;
    logic [7:0]              shreg;
    logic [2:0]              bit_cnt;
    logic                    par_bit;
    logic                    brk_f, ext_f;
    logic                    frame_ok;

    assign filt_lo  = (filt_sr == '0);
    assign filt_hi  = &filt_sr;
    // High in the one cycle where the filtered clock is about to drop.
    assign fall     = filt_clk & filt_lo;
    // Odd parity over data plus parity bit, and a high stop bit.
    assign frame_ok = i_ps2_data_ok();

    function automatic logic i_ps2_data_ok();
        return dat_s2 & (^{shreg, par_bit});
    endfunction

    // Synchronisers and clock filter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            filt_sr  <= '1;
            filt_clk <= 1'b1;
        end else begin
            clk_s1  <= i_ps2_clk;
            clk_s2  <= clk_s1;
            dat_s1  <= i_ps2_data;
            dat_s2  <= dat_s1;
            filt_sr <= {filt_sr[FILTER_LEN-2:0], clk_s2};
            if (filt_lo)
                filt_clk <= 1'b0;
            else if (filt_hi)
                filt_clk <= 1'b1;
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt;
    logic          filt_edge;

    assign filt_edge = (filt_clk & filt_lo) | (~filt_clk & filt_hi);
`endif

    // Frame FSM, prefix flags and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
            brk_f   <= 1'b0;
            ext_f   <= 1'b0;
            o_valid <= 1'b0;
            o_code  <= '0;
            o_break <= 1'b0;
            o_ext   <= 1'b0;
            o_err   <= 1'b0;
            o_busy  <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
            to_cnt  <= '0;
`endif
        end else begin
            o_valid <= 1'b0;
            o_err   <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
            if (state == IDLE || filt_edge)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
`endif
            if (fall) begin
                unique case (state)
                    IDLE: begin
                        // A high start bit is a spurious edge.
                        if (!dat_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            o_busy  <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= dat_s2;
                        state   <= STOP;
                    end
                    STOP: begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        if (!frame_ok) begin
                            o_err <= 1'b1;
                            brk_f <= 1'b0;
                            ext_f <= 1'b0;
                        end else if (shreg == 8'hE0) begin
                            ext_f <= 1'b1;
                        end else if (shreg == 8'hF0) begin
                            brk_f <= 1'b1;
                        end else begin
                            o_valid <= 1'b1;
                            o_code  <= shreg;
                            o_break <= brk_f;
                            o_ext   <= ext_f;
                            brk_f   <= 1'b0;
                            ext_f   <= 1'b0;
                        end
                    end
                endcase
            end
`ifdef PS2_RX_TIMEOUT_EN
            else if (state != IDLE && to_cnt == TO_MAX) begin
                state  <= IDLE;
                o_busy <= 1'b0;
                o_err  <= 1'b1;
                brk_f  <= 1'b0;
                ext_f  <= 1'b0;
            end
`endif
        end
    end

endmodule
